vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_timing_gen.sv | 71 +++++++
 tb/tb_vga_timing_gen.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants and the sync/visibility decode
// used by the VGA timing generator.
package vga_pkg;

   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] H_FP     = 10'd16;
   localparam logic [9:0] H_SYNC   = 10'd96;
   localparam logic [9:0] H_BP     = 10'd48;
   localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam logic [9:0] V_ACTIVE = 10'd480;
   localparam logic [9:0] V_FP     = 10'd10;
   localparam logic [9:0] V_SYNC   = 10'd2;
   localparam logic [9:0] V_BP     = 10'd33;
   localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
   localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
   localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
   localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

   localparam logic [9:0] H_MAX = H_TOTAL - 10'd1;
   localparam logic [9:0] V_MAX = V_TOTAL - 10'd1;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic display_on;
      logic line_tick;
      logic frame_tick;
   } vga_sync_t;

   // Decode at the origin, also the value held while reset is asserted.
   localparam vga_sync_t SYNC_ORIGIN = '{hsync: 1'b1, vsync: 1'b1, display_on: 1'b1,
                                         line_tick: 1'b1, frame_tick: 1'b1};

   function automatic vga_sync_t decode_sync(input logic [9:0] hx, input logic [9:0] vy);
      vga_sync_t s;
      s.hsync      = !((hx >= H_SYNC_START) && (hx <= H_SYNC_END));
      s.vsync      = !((vy >= V_SYNC_START) && (vy <= V_SYNC_END));
      s.display_on = (hx < H_ACTIVE) && (vy < V_ACTIVE);
      s.line_tick  = (hx == 10'd0);
      s.frame_tick = (hx == 10'd0) && (vy == 10'd0);
      return s;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Fixed 640x480@60 Hz VGA raster generator: pixel/line counters, a frame
// counter and registered sync/blanking decode aligned with the counters.
module vga_timing_gen
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       line_tick,
   output logic       frame_tick,
   output logic [8:0] frame_count
);

   logic [9:0] h_count;
   logic [9:0] v_count;
   logic [8:0] frame_cnt;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic [8:0] frame_next;
   logic       h_wrap;
   vga_sync_t  sync_q;
   vga_sync_t  sync_next;

   // Out-of-range counts are folded back to zero instead of running on.
   always_comb begin
      h_wrap     = (h_count >= H_MAX);
      h_next     = h_wrap ? 10'd0 : h_count + 10'd1;
      v_next     = v_count;
      frame_next = frame_cnt;
      if (v_count > V_MAX) begin
         v_next = 10'd0;
      end else if (h_wrap) begin
         if (v_count == V_MAX) begin
            v_next     = 10'd0;
            frame_next = frame_cnt + 9'd1;
         end else begin
            v_next = v_count + 10'd1;
         end
      end
      sync_next = decode_sync(h_next, v_next);
   end

   // Decoding next-state counts keeps the registered flags in step with x/y.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_count   <= 10'd0;
         v_count   <= 10'd0;
         frame_cnt <= 9'd0;
         sync_q    <= SYNC_ORIGIN;
      end else begin
         h_count   <= h_next;
         v_count   <= v_next;
         frame_cnt <= frame_next;
         sync_q    <= sync_next;
      end
   end

   assign x           = h_count;
   assign y           = v_count;
   assign frame_count = frame_cnt;
   assign hsync       = sync_q.hsync;
   assign vsync       = sync_q.vsync;
   assign display_on  = sync_q.display_on;
   assign line_tick   = sync_q.line_tick;
   assign frame_tick  = sync_q.frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: raster-position reference model,
// literal pins on line/frame statistics, wraps, out-of-range and async reset.
module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] x;
   logic [9:0] y;
   logic       hsync;
   logic       vsync;
   logic       display_on;
   logic       line_tick;
   logic       frame_tick;
   logic [8:0] frame_count;

   int errors = 0;
   int checks = 0;

   int mx = 0;
   int my = 0;
   int mframe = 0;

   logic [9:0] load_x;
   logic [9:0] load_y;
   logic [8:0] load_f;

   int hs_low, hs_first, hs_last, disp_cnt, line_ticks, frame_ticks;
   int vs_low, vs_first_x, vs_first_y, rise_cnt, rise_x, rise_y;
   logic prev_vs;

   vga_timing_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .x          (x),
      .y          (y),
      .hsync      (hsync),
      .vsync      (vsync),
      .display_on (display_on),
      .line_tick  (line_tick),
      .frame_tick (frame_tick),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Raster position advances one pixel per clock; 800 pixels per line, 525 lines per frame.
   function automatic void modelStep();
      mx++;
      if (mx == 800) begin
         mx = 0;
         my++;
         if (my == 525) begin
            my = 0;
            mframe = (mframe + 1) % 512;
         end
      end
   endfunction

   task automatic compareModel();
      checkOutput("x", int'(x), mx);
      checkOutput("y", int'(y), my);
      checkOutput("hsync", int'(hsync), (mx >= 656 && mx < 656 + 96) ? 0 : 1);
      checkOutput("vsync", int'(vsync), (my >= 490 && my < 490 + 2) ? 0 : 1);
      checkOutput("display_on", int'(display_on), (mx < 640 && my < 480) ? 1 : 0);
      checkOutput("line_tick", int'(line_tick), (mx == 0) ? 1 : 0);
      checkOutput("frame_tick", int'(frame_tick), (mx == 0 && my == 0) ? 1 : 0);
      checkOutput("frame_count", int'(frame_count), mframe);
   endtask

   task automatic clearStats();
      hs_low = 0; hs_first = -1; hs_last = -1; disp_cnt = 0;
      line_ticks = 0; frame_ticks = 0; vs_low = 0; vs_first_x = -1;
      vs_first_y = -1; rise_cnt = 0; rise_x = -1; rise_y = -1;
      prev_vs = vsync;
   endtask

   task automatic sampleStats();
      if (!hsync) begin
         if (hs_low == 0) hs_first = mx;
         hs_low++;
         hs_last = mx;
      end
      if (display_on) disp_cnt++;
      if (line_tick) line_ticks++;
      if (frame_tick) frame_ticks++;
      if (!vsync) begin
         if (vs_low == 0) begin
            vs_first_x = mx;
            vs_first_y = my;
         end
         vs_low++;
      end
      if (vsync && !prev_vs) begin
         rise_cnt++;
         rise_x = mx;
         rise_y = my;
      end
      prev_vs = vsync;
   endtask

   // Each cycle: model follows the edge, outputs sampled 2 time units later.
   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (rst_n) modelStep();
         #2;
         compareModel();
         sampleStats();
      end
   endtask

   // Jump the raster to an arbitrary position between clock edges.
   task automatic applyStimulus(input int lx, input int ly, input int lf);
      load_x = 10'(lx);
      load_y = 10'(ly);
      load_f = 9'(lf);
      force dut.h_count = load_x;
      force dut.v_count = load_y;
      force dut.frame_cnt = load_f;
      #1;
      release dut.h_count;
      release dut.v_count;
      release dut.frame_cnt;
      mx = lx;
      my = ly;
      mframe = lf;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_x"}, int'(x), 0);
      checkOutput({tag, "_y"}, int'(y), 0);
      checkOutput({tag, "_frame_count"}, int'(frame_count), 0);
      checkOutput({tag, "_hsync"}, int'(hsync), 1);
      checkOutput({tag, "_vsync"}, int'(vsync), 1);
      checkOutput({tag, "_display_on"}, int'(display_on), 1);
      checkOutput({tag, "_line_tick"}, int'(line_tick), 1);
      checkOutput({tag, "_frame_tick"}, int'(frame_tick), 1);
   endtask

   initial begin
      int lx, ly, lf;

      clearStats();
      runCycles(3);
      checkResetValues("reset");

      rst_n = 1'b1;
      runCycles(1);
      checkOutput("first_edge_x", int'(x), 1);
      checkOutput("first_edge_y", int'(y), 0);
      checkOutput("first_edge_frame_count", int'(frame_count), 0);

      // Whole of line 1, x = 0..799.
      runCycles(798);
      clearStats();
      runCycles(800);
      checkOutput("line1_hsync_low_cycles", hs_low, 96);
      checkOutput("line1_hsync_first_low_x", hs_first, 656);
      checkOutput("line1_hsync_last_low_x", hs_last, 751);
      checkOutput("line1_display_on_cycles", disp_cnt, 640);
      checkOutput("line1_line_ticks", line_ticks, 1);

      // Lines 489..492 around vertical sync.
      applyStimulus(799, 488, 3);
      clearStats();
      prev_vs = 1'b1;
      runCycles(3200);
      checkOutput("vsync_low_cycles", vs_low, 1600);
      checkOutput("vsync_first_low_x", vs_first_x, 0);
      checkOutput("vsync_first_low_y", vs_first_y, 490);
      checkOutput("vsync_rise_count", rise_cnt, 1);
      checkOutput("vsync_rise_x", rise_x, 0);
      checkOutput("vsync_rise_y", rise_y, 492);
      checkOutput("blank_display_on_cycles", disp_cnt, 0);
      checkOutput("blank_line_ticks", line_ticks, 4);
      checkOutput("blank_frame_ticks", frame_ticks, 0);

      // Corner wrap (799,524) -> (0,0).
      applyStimulus(795, 524, 37);
      runCycles(5);
      checkOutput("corner_x", int'(x), 0);
      checkOutput("corner_y", int'(y), 0);
      checkOutput("corner_frame_tick", int'(frame_tick), 1);
      checkOutput("corner_line_tick", int'(line_tick), 1);
      checkOutput("corner_display_on", int'(display_on), 1);
      checkOutput("corner_frame_count", int'(frame_count), 38);

      applyStimulus(799, 524, 511);
      clearStats();
      runCycles(1);
      checkOutput("frame_count_wrap", int'(frame_count), 0);
      checkOutput("frame_count_wrap_tick", frame_ticks, 1);

      for (int i = 0; i < 12; i++) begin
         lx = $urandom_range(0, 799);
         ly = ($urandom_range(0, 3) == 0) ? $urandom_range(520, 524) : $urandom_range(0, 524);
         lf = $urandom_range(0, 511);
         applyStimulus(lx, ly, lf);
         runCycles($urandom_range(1, 1500));
      end

      // Out-of-range counts fold back to zero.
      applyStimulus(1000, 600, 7);
      @(posedge clk);
      #2;
      checkOutput("oor_x", int'(x), 0);
      checkOutput("oor_y", int'(y), 0);
      applyStimulus(900, 100, 7);
      @(posedge clk);
      #2;
      checkOutput("oor_x_only", int'(x), 0);
      checkOutput("oor_x_only_line_tick", int'(line_tick), 1);

      rst_n = 1'b0;
      mx = 0; my = 0; mframe = 0;
      runCycles(2);
      rst_n = 1'b1;
      runCycles(20);

      // Asynchronous reset at (300,200), between clock edges.
      applyStimulus(290, 200, 5);
      runCycles(10);
      checkOutput("pre_async_x", int'(x), 300);
      #1;
      rst_n = 1'b0;
      mx = 0; my = 0; mframe = 0;
      #1;
      checkResetValues("async_rst");
      runCycles(2);
      rst_n = 1'b1;
      runCycles(1);
      checkOutput("restart_x", int'(x), 1);
      checkOutput("restart_y", int'(y), 0);
      checkOutput("restart_frame_count", int'(frame_count), 0);
      runCycles(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
